// File: rtl/mult_arb.sv
// mult_arb: two requesters share one pipelined WxW multiplier.
// Round-robin arbitration on the request side; products come back on the
// requesting channel after LAT cycles, as a one-cycle pulse.
// Optional build macro MULT_ARB_FIXED_PRIO_EN: ch0 always wins contention
// and the round-robin pointer is removed (ch1 may starve).

module mult_arb #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   ch0_din_a,
    input  logic [W-1:0]   ch0_din_b,
    input  logic           ch0_sign,
    input  logic           ch0_vld,
    output logic           ch0_rdy,
    input  logic [W-1:0]   ch1_din_a,
    input  logic [W-1:0]   ch1_din_b,
    input  logic           ch1_sign,
    input  logic           ch1_vld,
    output logic           ch1_rdy,
    output logic [2*W-1:0] ch0_dout,
    output logic           ch0_dout_vld,
    output logic [2*W-1:0] ch1_dout,
    output logic           ch1_dout_vld,
    output logic           busy
);

    // Handshake: a request transfers on a cycle where chX_vld && chX_rdy.
    // While vld=1 and rdy=0 the requester holds din/sign stable; rdy is a
    // combinational grant, never asserted during rst, at most one per cycle.

    typedef struct packed {
        logic         vld;
        logic         tag;   // 0 = ch0, 1 = ch1
        logic         sign;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } stage_t;

    logic           acc;
    logic           acc_tag;
    logic           acc_sign;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;
    stage_t         last;
    logic           pipe_any;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] prod;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Fixed priority grant: ch1 only gets the multiplier when ch0 is idle.
    always_comb begin
        ch0_rdy = 1'b0;
        ch1_rdy = 1'b0;
        if (!rst) begin
            if (ch0_vld)
                ch0_rdy = 1'b1;
            else if (ch1_vld)
                ch1_rdy = 1'b1;
        end
    end
`else
    // ptr = 0 favours ch0, ptr = 1 favours ch1.
    logic ptr;

    // Round-robin grant: pointer only matters when both channels request.
    always_comb begin
        ch0_rdy = 1'b0;
        ch1_rdy = 1'b0;
        if (!rst) begin
            if (ch0_vld && (!ch1_vld || !ptr))
                ch0_rdy = 1'b1;
            else if (ch1_vld)
                ch1_rdy = 1'b1;
        end
    end

    // After an accept, favour the channel that was not granted.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (acc)
            ptr <= ~acc_tag;
    end
`endif

    // Select the accepted channel's operands for pipeline entry.
    always_comb begin
        acc      = ch0_rdy | ch1_rdy;
        acc_tag  = ch1_rdy;
        acc_a    = ch1_rdy ? ch1_din_a : ch0_din_a;
        acc_b    = ch1_rdy ? ch1_din_b : ch0_din_b;
        acc_sign = ch1_rdy ? ch1_sign  : ch0_sign;
    end

    // Operand pipeline: LAT-1 registered stages feed the output register,
    // so the total accept-to-result latency is exactly LAT.
    if (LAT <= 1) begin : g_no_pipe
        assign last     = '{vld: acc, tag: acc_tag, sign: acc_sign, a: acc_a, b: acc_b};
        assign pipe_any = 1'b0;
    end else begin : g_pipe
        stage_t pipe [LAT-1];

        // Shift accepted operands and their channel tag toward the multiplier.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LAT-1; k++)
                    pipe[k] <= '0;
            end else begin
                pipe[0] <= '{vld: acc, tag: acc_tag, sign: acc_sign, a: acc_a, b: acc_b};
                for (int k = 1; k < LAT-1; k++)
                    pipe[k] <= pipe[k-1];
            end
        end

        // Any occupied stage means a result is still owed.
        always_comb begin
            pipe_any = 1'b0;
            for (int k = 0; k < LAT-1; k++)
                pipe_any = pipe_any | pipe[k].vld;
        end

        assign last = pipe[LAT-2];
    end

    // Extend each operand to 2W bits (sign or zero) and keep the low 2W bits
    // of the product; this is exact for every signed and unsigned pair.
    always_comb begin
        ext_a = {{W{last.sign & last.a[W-1]}}, last.a};
        ext_b = {{W{last.sign & last.b[W-1]}}, last.b};
        prod  = ext_a * ext_b;
    end

    // Route the finished product to the tagged channel; the other channel's
    // dout holds. busy covers every request whose pulse is still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch0_dout     <= '0;
            ch0_dout_vld <= 1'b0;
            ch1_dout     <= '0;
            ch1_dout_vld <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ch0_dout_vld <= last.vld & ~last.tag;
            ch1_dout_vld <= last.vld &  last.tag;
            if (last.vld && !last.tag)
                ch0_dout <= prod;
            if (last.vld && last.tag)
                ch1_dout <= prod;
            busy <= acc | pipe_any;
        end
    end

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: vector table of single requests plus
// hand-written sequences for back-to-back, contention, reset and hold cases.

module tb_mult_arb;

    localparam int W   = 8;
    localparam int LAT = 2;

    logic           clk;
    logic           rst;
    logic [W-1:0]   ch0_din_a, ch0_din_b, ch1_din_a, ch1_din_b;
    logic           ch0_sign, ch0_vld, ch0_rdy;
    logic           ch1_sign, ch1_vld, ch1_rdy;
    logic [2*W-1:0] ch0_dout, ch1_dout;
    logic           ch0_dout_vld, ch1_dout_vld;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // {expected cycle, expected product}
    logic [47:0] exp0_q[$];
    logic [47:0] exp1_q[$];
    logic [15:0] held [2];

    typedef struct {
        logic        ch;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs [12];

    mult_arb #(.W(W), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ch0_din_a    (ch0_din_a),
        .ch0_din_b    (ch0_din_b),
        .ch0_sign     (ch0_sign),
        .ch0_vld      (ch0_vld),
        .ch0_rdy      (ch0_rdy),
        .ch1_din_a    (ch1_din_a),
        .ch1_din_b    (ch1_din_b),
        .ch1_sign     (ch1_sign),
        .ch1_vld      (ch1_vld),
        .ch1_rdy      (ch1_rdy),
        .ch0_dout     (ch0_dout),
        .ch0_dout_vld (ch0_dout_vld),
        .ch1_dout     (ch1_dout),
        .ch1_dout_vld (ch1_dout_vld),
        .busy         (busy)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia, ib, p;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return 16'(p);
    endfunction

    // scoreboard: every result pulse must match the oldest expectation,
    // both in value and in the cycle it appears
    always @(negedge clk) begin
        if (ch0_dout_vld === 1'b1) begin
            if (exp0_q.size() == 0) chk("ch0_unexpected_pulse", {32'(cyc), ch0_dout}, 48'h0);
            else chk("ch0_result", {32'(cyc), ch0_dout}, exp0_q.pop_front());
        end
        if (ch1_dout_vld === 1'b1) begin
            if (exp1_q.size() == 0) chk("ch1_unexpected_pulse", {32'(cyc), ch1_dout}, 48'h0);
            else chk("ch1_result", {32'(cyc), ch1_dout}, exp1_q.pop_front());
        end
    end

    // driver helpers
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic grab();
        @(negedge clk);
        if (ch0_vld && ch0_rdy) exp0_q.push_back({32'(cyc + LAT), model(ch0_din_a, ch0_din_b, ch0_sign)});
        if (ch1_vld && ch1_rdy) exp1_q.push_back({32'(cyc + LAT), model(ch1_din_a, ch1_din_b, ch1_sign)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch0_vld = 1'b1;
        ch1_vld = 1'b1;
        adv();
        @(negedge clk);
        chk("rst_ch0_rdy", 48'(ch0_rdy), 48'h0);
        chk("rst_ch1_rdy", 48'(ch1_rdy), 48'h0);
        adv();
        rst = 1'b0;
        ch0_vld = 1'b0;
        ch1_vld = 1'b0;
        held[0] = '0;
        held[1] = '0;
    endtask

    task automatic drive_ch(input logic ch, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (ch == 1'b0) begin
            ch0_din_a = a; ch0_din_b = b; ch0_sign = s; ch0_vld = 1'b1;
        end else begin
            ch1_din_a = a; ch1_din_b = b; ch1_sign = s; ch1_vld = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic own_rdy, oth_rdy, own_vld, oth_vld;
        logic [15:0] own_dout, oth_dout;
        drive_ch(v.ch, v.a, v.b, v.s);
        drive_ch(~v.ch, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        if (v.ch) ch0_vld = 1'b0; else ch1_vld = 1'b0;
        grab();
        own_rdy = v.ch ? ch1_rdy : ch0_rdy;
        oth_rdy = v.ch ? ch0_rdy : ch1_rdy;
        chk("tbl_rdy_own", 48'(own_rdy), 48'h1);
        chk("tbl_rdy_other", 48'(oth_rdy), 48'h0);
        adv();
        ch0_vld = 1'b0;
        ch1_vld = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            chk("tbl_early_vld", 48'(v.ch ? ch1_dout_vld : ch0_dout_vld), 48'h0);
            chk("tbl_busy_inflight", 48'(busy), 48'h1);
            adv();
        end
        @(negedge clk);
        own_vld  = v.ch ? ch1_dout_vld : ch0_dout_vld;
        oth_vld  = v.ch ? ch0_dout_vld : ch1_dout_vld;
        own_dout = v.ch ? ch1_dout : ch0_dout;
        oth_dout = v.ch ? ch0_dout : ch1_dout;
        chk("tbl_vld_own", 48'(own_vld), 48'h1);
        chk("tbl_dout_own", 48'(own_dout), 48'(v.prod));
        chk("tbl_vld_other", 48'(oth_vld), 48'h0);
        chk("tbl_dout_other_held", 48'(oth_dout), 48'(held[~v.ch]));
        chk("tbl_busy_at_pulse", 48'(busy), 48'h1);
        held[v.ch] = v.prod;
        adv();
        @(negedge clk);
        chk("tbl_vld_after", 48'(v.ch ? ch1_dout_vld : ch0_dout_vld), 48'h0);
        chk("tbl_dout_holds", 48'(v.ch ? ch1_dout : ch0_dout), 48'(v.prod));
        chk("tbl_busy_idle", 48'(busy), 48'h0);
        adv();
    endtask

    initial begin
        int g0, g1, i0, i1;
        logic exp_g0;

        // vector table: channel, A, B, sign, hand-computed product
        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[2]  = '{1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3]  = '{1'b1, 8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[4]  = '{1'b0, 8'h80, 8'h02, 1'b0, 16'h0100};
        vecs[5]  = '{1'b1, 8'h80, 8'h02, 1'b1, 16'hFF00};
        vecs[6]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[7]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[8]  = '{1'b0, 8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[9]  = '{1'b0, 8'h00, 8'h5A, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 8'h03, 8'hFD, 1'b1, 16'hFFF7};
        vecs[11] = '{1'b0, 8'h12, 8'h34, 1'b0, 16'h03A8};

        ch0_din_a = '0; ch0_din_b = '0; ch0_sign = 1'b0;
        ch1_din_a = '0; ch1_din_b = '0; ch1_sign = 1'b0;
        ch0_vld = 1'b0; ch1_vld = 1'b0;
        rst = 1'b1;

        // reset state
        do_reset();
        @(negedge clk);
        chk("reset_ch0_dout", 48'(ch0_dout), 48'h0);
        chk("reset_ch1_dout", 48'(ch1_dout), 48'h0);
        chk("reset_ch0_vld", 48'(ch0_dout_vld), 48'h0);
        chk("reset_ch1_vld", 48'(ch1_dout_vld), 48'h0);
        chk("reset_busy", 48'(busy), 48'h0);
        adv();

        // table-driven single requests
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // back-to-back signed corners on ch1: consecutive results, in order
        drive_ch(1'b1, 8'hFF, 8'hFF, 1'b1);
        grab(); chk("b2b_rdy0", 48'(ch1_rdy), 48'h1); adv();
        drive_ch(1'b1, 8'h80, 8'h7F, 1'b1);
        grab(); chk("b2b_rdy1", 48'(ch1_rdy), 48'h1); adv();
        drive_ch(1'b1, 8'h80, 8'h80, 1'b1);
        grab(); chk("b2b_rdy2", 48'(ch1_rdy), 48'h1); adv();
        ch1_vld = 1'b0;
        repeat (LAT + 1) adv();
        chk("b2b_drained", 48'(exp1_q.size()), 48'h0);

        // contention from reset: both channels hold vld for 6 cycles
        do_reset();
        g0 = 0; g1 = 0; i0 = 0; i1 = 0;
        for (int i = 0; i < 6; i++) begin
            drive_ch(1'b0, 8'(8'h10 + i0), 8'h03, 1'b0);
            drive_ch(1'b1, 8'(8'hF0 + i1), 8'h05, 1'b1);
            grab();
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_g0 = 1'b1;
`else
            exp_g0 = (i % 2 == 0);
`endif
            chk("cont_ch0_rdy", 48'(ch0_rdy), 48'(exp_g0));
            chk("cont_ch1_rdy", 48'(ch1_rdy), 48'(!exp_g0));
            if (ch0_rdy) begin g0++; i0++; end
            if (ch1_rdy) begin g1++; i1++; end
            adv();
        end
        ch0_vld = 1'b0;
        ch1_vld = 1'b0;
        repeat (LAT + 1) adv();
`ifdef MULT_ARB_FIXED_PRIO_EN
        chk("cont_g0", 48'(g0), 48'd6);
        chk("cont_g1", 48'(g1), 48'd0);
`else
        chk("cont_g0", 48'(g0), 48'd3);
        chk("cont_g1", 48'(g1), 48'd3);
`endif
        chk("cont_drained", 48'(exp0_q.size() + exp1_q.size()), 48'h0);
        @(negedge clk);
        chk("cont_busy_idle", 48'(busy), 48'h0);
        adv();

        // reset mid-operation: two ch0 accepts (pointer now favours ch1),
        // then rst; only the result already registered may pulse
        drive_ch(1'b0, 8'h11, 8'h11, 1'b0);
        grab(); chk("mid_rdy_a", 48'(ch0_rdy), 48'h1); adv();
        drive_ch(1'b0, 8'h22, 8'h02, 1'b0);
        @(negedge clk); chk("mid_rdy_b", 48'(ch0_rdy), 48'h1); adv();
        ch0_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk); chk("mid_rdy_in_rst", 48'(ch0_rdy), 48'h0); adv();
        rst = 1'b0;
        // hold stability: ch1 held while ch0 wins, then accepted unchanged
        drive_ch(1'b0, 8'h05, 8'h07, 1'b0);
        drive_ch(1'b1, 8'hFE, 8'h03, 1'b1);
        grab();
        chk("mid_after_ch0_vld", 48'(ch0_dout_vld), 48'h0);
        chk("mid_after_ch1_vld", 48'(ch1_dout_vld), 48'h0);
        chk("mid_after_ch0_dout", 48'(ch0_dout), 48'h0);
        chk("mid_after_ch1_dout", 48'(ch1_dout), 48'h0);
        chk("mid_after_busy", 48'(busy), 48'h0);
        chk("mid_ptr_ch0_first", 48'(ch0_rdy), 48'h1);
        chk("hold_ch1_waits", 48'(ch1_rdy), 48'h0);
        adv();
        ch0_vld = 1'b0;
        grab();
        chk("hold_ch1_granted", 48'(ch1_rdy), 48'h1);
        adv();
        ch1_vld = 1'b0;
        repeat (LAT - 1) adv();
        @(negedge clk);
        chk("hold_pulse", 48'(ch1_dout_vld), 48'h1);
        chk("hold_product", 48'(ch1_dout), 48'hFFFA);
        chk("hold_busy_at_pulse", 48'(busy), 48'h1);
        adv();
        @(negedge clk);
        chk("hold_busy_falls", 48'(busy), 48'h0);
        adv();
        repeat (LAT + 1) adv();
        chk("final_drained", 48'(exp0_q.size() + exp1_q.size()), 48'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
Name: mult_arb

Overview:
- Shares one pipelined 8x8 multiplier between two requesters (ch0, ch1), each able to request signed or unsigned multiplication.
- Round-robin arbitration with valid/ready on the request side; results return per-channel with a valid strobe after a fixed latency.
- Sits in front of the DSP multiply datapath; replaces duplicated multipliers where two producers need products at an aggregate rate of at most 1 per cycle.

Parameters:
- W, 8, operand width; product width is 2*W.
- LAT, 2, multiplier pipeline depth in cycles from accept to result, minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ch0_din_a  in  W  channel 0 operand A.
- ch0_din_b  in  W  channel 0 operand B.
- ch0_sign  in  1  channel 0 mode: 1 = two's-complement operands, 0 = unsigned.
- ch0_vld  in  1  channel 0 request valid.
- ch0_rdy  out  1  channel 0 request accepted this cycle (combinational grant).
- ch1_din_a, ch1_din_b, ch1_sign, ch1_vld, ch1_rdy: same as ch0, for channel 1.
- ch0_dout  out  2W  channel 0 product.
- ch0_dout_vld  out  1  channel 0 product valid, one-cycle pulse.
- ch1_dout, ch1_dout_vld: same as ch0, for channel 1.
- busy  out  1  high while any accepted request is still in the pipeline.

Behaviour:
- Reset (synchronous, active-high rst sampled on posedge clk):
  - All registered outputs go to 0: dout, dout_vld, busy.
  - Round-robin pointer set so ch0 has priority.
  - Pipeline valid/tag stages cleared. In-flight requests are dropped, and no dout_vld may appear from them after reset.
  - ch*_rdy is 0 while rst is high.
- Arbitration (combinational from vld and the pointer):
  - Only ch0_vld high: ch0_rdy = 1. Only ch1_vld high: ch1_rdy = 1.
  - Both high: grant the channel the pointer favours.
  - At most one rdy is high per cycle. A request is accepted when vld & rdy.
- Pointer update on accept: pointer moves to favour the non-granted channel. No accept: pointer holds.
  - Result: alternating grants under continuous contention; a lone requester gets every cycle.
- Requester rules: must hold din/sign stable while vld=1 && rdy=0. The arbiter never drops a held request.
- Arithmetic:
  - sign=0: product = zero-extended A * zero-extended B, 2W bits.
  - sign=1: product = sign-extended A * sign-extended B, truncated to 2W bits. Exact for all operands, including -2^(W-1) * -2^(W-1).
- Pipeline:
  - Operands, sign and a 1-bit channel tag are registered on accept and carried LAT stages alongside a valid bit.
  - Throughput is 1 accept per cycle total.
- Latency: a request accepted at cycle N produces the product on chX_dout with chX_dout_vld = 1 during cycle N+LAT.
- Result routing:
  - Only the tagged channel's dout/dout_vld update. The other channel's dout holds its last value, with its dout_vld = 0.
  - dout holds its value between pulses.
- busy = OR of all pipeline valid bits. No accept this cycle and the pipeline is empty: busy = 0 on the next cycle.
- There is no output backpressure; consumers must take results on the pulse.

Optional Feature:
- Macro MULT_ARB_FIXED_PRIO_EN.
- Defined: ch0 always wins contention and the pointer logic is removed. ch1 is granted only when ch0_vld = 0, so ch1 starvation is allowed.
- Undefined: round-robin as specified above.

Test Plan:
- Latency check, LAT=2: ch0 unsigned A=8'hFF, B=8'hFF, accepted at cycle 5 -> ch0_dout = 16'hFE01 with ch0_dout_vld = 1 at cycle 7 only; ch1_dout_vld stays 0.
- Signed corners on ch1, back-to-back:
  - -1 * -1 -> 16'h0001
  - -128 * 127 -> 16'hC080
  - -128 * -128 -> 16'h4000
  - Results appear on consecutive cycles, in order.
- Contention: both channels hold vld for 6 cycles from reset -> grants ch0, ch1, ch0, ch1, ch0, ch1; each channel gets 3 pulses in accept order. With MULT_ARB_FIXED_PRIO_EN: 6 ch0 grants, 0 ch1 grants.
- Mixed mode: ch0 sign=0 with 8'h80 * 8'h02 -> 16'h0100; ch1 sign=1 with the same operands -> 16'hFF00; each result is routed to the correct channel.
- Reset mid-operation: accept 2 requests, assert rst for 1 cycle before the results emerge -> no dout_vld afterwards, dout = 0, busy = 0; the next request from ch0 is granted first.
- Hold stability: ch1_vld held while ch0 is granted -> ch1 operands are accepted unchanged the following cycle and the correct product is returned; busy falls 1 cycle after the last result pulse.
